// File: rtl/led_frame_controller.sv
// led_frame_controller: decodes framed byte commands (header B0-B3, mode bytes,
// AA terminator) into per-LED off/on/blink modes and returns one ack byte per
// completed frame over a valid/ready handshake.
// Optional feature macro: LED_FRAME_BLINK_EN (blink mode and blink counter).
module led_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES    = 1_000_000,
  parameter int unsigned BLINK_HALF_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] led,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StCmd, StAck} state_e;
  typedef enum logic [1:0] {ModeOff = 2'd0, ModeOn = 2'd1, ModeBlink = 2'd2} mode_e;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  mode_e         mode_q [4];
  mode_e         mode_d [4];
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          err_q, err_d;
  logic [3:0]    led_q, led_d;
  logic          phase_d;

`ifdef LED_FRAME_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF_PERIOD - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q;

  // Free-running blink counter; toggles the phase at the end of each half period.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  logic unused_blink_param;
  assign unused_blink_param = ^BLINK_HALF_PERIOD;
  assign phase_d = 1'b0;
`endif

  // Frame decoder: next state, mode updates, ack generation and error pulses.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tcnt_d     = tcnt_q;
    mode_d     = mode_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data[7:2] == 6'b101100) begin
            sel_d   = rx_data[1:0];
            tcnt_d  = '0;
            state_d = StCmd;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCmd: begin
        if (rx_valid) begin
          // An arriving byte always beats a coincident timeout.
          tcnt_d = '0;
          case (rx_data)
            8'h00: mode_d[sel_q] = ModeOff;
            8'hFF: mode_d[sel_q] = ModeOn;
`ifdef LED_FRAME_BLINK_EN
            8'h55: mode_d[sel_q] = ModeBlink;
`endif
            8'hAA: begin
              tx_data_d  = {6'b101000, sel_q};
              tx_valid_d = 1'b1;
              state_d    = StAck;
            end
            default: err_d = 1'b1;
          endcase
        end else if (tcnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StAck: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
        if (rx_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // LED drive from the next-cycle modes and phase, so writes show after one edge.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 4; i++) begin
      case (mode_d[i])
        ModeOn:    led_d[i] = 1'b1;
        ModeBlink: led_d[i] = phase_d;
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= 2'd0;
      tcnt_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= ModeOff;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tcnt_q     <= tcnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      led_q      <= led_d;
      for (int i = 0; i < 4; i++) begin
        mode_q[i] <= mode_d[i];
      end
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign led      = led_q;
  assign err      = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_led_frame_controller.sv
// Directed self-checking bench for led_frame_controller (TIMEOUT_CYCLES=16,
// BLINK_HALF_PERIOD=4). Blink checks follow LED_FRAME_BLINK_EN.
module tb_led_frame_controller;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] led;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_frame_controller #(
    .TIMEOUT_CYCLES    (16),
    .BLINK_HALF_PERIOD (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .led      (led),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset edge; expected blink phase is (cyc/4)%2.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_led", led, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_err", err, 1'b0);

    // Basic frame
    send(8'hB2);
    check("basic_busy", busy, 1'b1);
    send(8'hFF);
    check("basic_led", led, 4'b0100);
    check("basic_err", err, 1'b0);
    send(8'hAA);
    check("basic_tx_valid", tx_valid, 1'b1);
    check("basic_tx_data", tx_data, 8'hA2);
    tick();
    check("basic_tx_drop", tx_valid, 1'b0);
    check("basic_idle", busy, 1'b0);

    // Independence and last-wins
    do_reset();
    send(8'hB0);
    send(8'hFF);
    send(8'hAA);
    check("ind_ack0", tx_data, 8'hA0);
    tick();
    send(8'hB3);
    send(8'hFF);
    send(8'h00);
    check("ind_off", led, 4'b0001);
    send(8'hFF);
    check("ind_led", led, 4'b1001);
    send(8'hAA);
    check("ind_ack3", tx_data, 8'hA3);
    check("ind_ack3_v", tx_valid, 1'b1);
    tick();

    // Backpressure with a byte dropped during ACK
    tx_ready = 1'b0;
    send(8'hB1);
    send(8'hFF);
    check("bp_led", led, 4'b1011);
    send(8'hAA);
    for (int i = 0; i < 10; i++) begin
      rx_data  = 8'h12;
      rx_valid = (i == 3);
      tick();
      rx_valid = 1'b0;
      check("bp_tx_valid", tx_valid, 1'b1);
      check("bp_tx_data", tx_data, 8'hA1);
      check("bp_err", err, (i == 3) ? 1'b1 : 1'b0);
    end
    check("bp_busy", busy, 1'b1);
    tx_ready = 1'b1;
    tick();
    check("bp_idle", busy, 1'b0);
    check("bp_tx_drop", tx_valid, 1'b0);

    // Timeout after 16 idle cycles, mode kept
    do_reset();
    send(8'hB1);
    send(8'hFF);
    check("to_led", led, 4'b0010);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        check("to_busy_wait", busy, 1'b1);
        check("to_err_wait", err, 1'b0);
      end
    end
    check("to_busy", busy, 1'b0);
    check("to_err", err, 1'b1);
    check("to_no_ack", tx_valid, 1'b0);
    tick();
    check("to_err_pulse", err, 1'b0);
    check("to_led_kept", led, 4'b0010);

    // Bytes at idle cycle 15 and at the would-be timeout cycle keep the frame alive
    send(8'hB2);
    repeat (14) tick();
    send(8'hFF);
    check("nto15_busy", busy, 1'b1);
    check("nto15_err", err, 1'b0);
    check("nto15_led", led, 4'b0110);
    repeat (15) tick();
    send(8'h00);
    check("nto16_busy", busy, 1'b1);
    check("nto16_err", err, 1'b0);
    check("nto16_led", led, 4'b0010);
    send(8'hAA);
    check("nto_ack", tx_data, 8'hA2);
    tick();

    // Blink
    do_reset();
    send(8'hB0);
    send(8'h55);
`ifdef LED_FRAME_BLINK_EN
    check("blink_err", err, 1'b0);
    send(8'hAA);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("blink_led0", led[0], ((cyc / 4) % 2) != 0);
    end
`else
    check("noblink_err", err, 1'b1);
    check("noblink_led", led, 4'b0000);
    send(8'hAA);
    tick();
    repeat (6) tick();
    check("noblink_led_hold", led, 4'b0000);
`endif

    // Errors and reset
    do_reset();
    send(8'h33);
    check("idle_err", err, 1'b1);
    check("idle_busy", busy, 1'b0);
    tick();
    check("idle_err_pulse", err, 1'b0);
    send(8'hB1);
    send(8'hB3);
    check("hdr_in_cmd_err", err, 1'b1);
    send(8'hFF);
    check("hdr_no_resel", led, 4'b0010);
    send(8'hAA);
    tick();
    send(8'hB2);
    send(8'hFF);
    check("mid_led", led, 4'b0110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_led", led, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    tx_ready = 1'b0;
    send(8'hB1);
    send(8'hAA);
    check("ack_pending", tx_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ack_rst_tx_valid", tx_valid, 1'b0);
    check("ack_rst_tx_data", tx_data, 8'h00);
    check("ack_rst_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_controller.md
# led_frame_controller

Command-frame controller between the UART receiver/transmitter and the board's four LEDs. Consumes a byte stream with a valid strobe and decodes framed commands (select LED, set mode, end frame). It keeps an independent on/off/blink mode per LED and returns one acknowledge byte per completed frame to the UART transmitter over a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed inside a frame before it is abandoned. Must be ≥ 2.
- `BLINK_HALF_PERIOD`, default 25_000_000: cycles per blink phase. Must be ≥ 1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte, valid only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `tx_data` out 8: acknowledge byte.
- `tx_valid` out 1: acknowledge pending.
- `tx_ready` in 1: transmitter accepts `tx_data` when `tx_valid`&&`tx_ready`.
- `led` out 4: LED drive, registered.
- `busy` out 1: high whenever state ≠ IDLE.
- `err` out 1: one-cycle pulse on a protocol error.

## Operation
- **Reset values:** state IDLE; all modes OFF; `led`=0; `tx_valid`=0; `tx_data`=0x00; `err`=0; `busy`=0; blink counter 0; blink phase 0.
- **Per-LED mode register (2 bits):** OFF, ON, BLINK.
- **LED output:**
  - OFF → `led[i]`=0.
  - ON → `led[i]`=1.
  - BLINK → `led[i]`=blink phase.
  - LEDs are independent. Setting one LED never changes the others.
- **IDLE:**
  - `rx_valid` with 0xB0–0xB3 → sel=`rx_data[1:0]`, go to CMD, clear the timeout counter.
  - Any other byte → `err` pulse, stay in IDLE.
- **CMD:** each `rx_valid` clears the timeout counter.
  - 0x00 → mode[sel]=OFF.
  - 0xFF → mode[sel]=ON.
  - 0x55 → mode[sel]=BLINK.
  - 0xAA → `tx_data`=0xA0|sel, `tx_valid`=1, go to ACK.
  - Other byte → `err` pulse, stay in CMD, sel unchanged.
  - A frame may carry several mode bytes; the last one wins.
  - A header byte (0xB0–0xB3) inside CMD is an error. It does not reselect.
- **CMD timeout:** the counter increments every cycle without `rx_valid`. When it reaches TIMEOUT_CYCLES−1 → `err` pulse, go to IDLE, no acknowledge. Mode changes already applied are kept.
- **ACK:**
  - `tx_valid` and `tx_data` are held stable until `tx_valid`&&`tx_ready`.
  - On that handshake: `tx_valid`=0, go to IDLE.
  - `rx_valid` during ACK → byte dropped, `err` pulse.
- **Blink generator:** free-running counter. It toggles the phase and wraps to 0 when the count reaches BLINK_HALF_PERIOD−1. It is never restarted by commands.

## Timing
- A mode byte sampled with `rx_valid` at edge N → `led` shows the new value after edge N (1-cycle latency).
- 0xAA sampled at edge N → `tx_valid`=1 from edge N onward. With `tx_ready` held high, `tx_valid` drops at edge N+1 and `busy` drops at edge N+1.
- A byte arriving in the same cycle the timeout would fire: the byte wins, the timeout does not fire, and the byte is processed normally.
- A blink toggle coinciding with a mode write: the mode write applies and uses the post-toggle phase.
- `err` is a single-cycle pulse, asserted the cycle after the offending byte is sampled.
- `reset` asserted mid-frame or mid-ACK overrides everything in that cycle:
  - all reset values are restored on the next edge;
  - a pending acknowledge is discarded.

## Configuration
- Macro `LED_FRAME_BLINK_EN`.
- **Defined:** BLINK mode and the blink counter are built; 0x55 in CMD selects BLINK.
- **Undefined:** no blink counter is synthesized; 0x55 in CMD is an unknown byte (`err` pulse, mode unchanged); mode storage may be 1 bit per LED. All other behaviour is identical.

## Test plan
- **Basic frame:** after reset, send B2, FF, AA with `tx_ready`=1 → `led`=4'b0100 one cycle after FF; `tx_data`=0xA2 with `tx_valid` for exactly 1 cycle; `busy` back to 0.
- **Independence / last-wins:** send frame B0, FF, AA, then frame B3, FF, 00, FF, AA → `led`=4'b1001; acks 0xA0 then 0xA3.
- **Backpressure:** frame B1, FF, AA with `tx_ready`=0 for 10 cycles, plus a byte 0x12 during ACK → `tx_valid`/`tx_data`=0xA1 stable for all 10 cycles; one `err` pulse; IDLE one cycle after `tx_ready` rises.
- **Timeout:** TIMEOUT_CYCLES=16; send B1, FF, then silence → `led[1]`=1 kept; `err` pulse and `busy`=0 after 16 idle cycles; no `tx_valid`. Then a byte exactly at idle cycle 15 → no timeout.
- **Blink (macro defined, BLINK_HALF_PERIOD=4):** frame B0, 55, AA → `led[0]` toggles every 4 cycles in phase with the free-running counter. With the macro undefined, the same stimulus → `err` pulse and `led[0]` stays 0.
- **Errors and reset:** byte 0x33 in IDLE → `err` pulse, state unchanged. Reset asserted during CMD after B2, FF → `led`=0, `busy`=0, `tx_valid`=0 on the next edge.
